// File: rtl/vcxo_lock_monitor.sv
// Lock qualifier for the VCXO discipline loop: hysteresis lock FSM, lock-loss counter,
// and a 48-bit MSB-first serial status frame returned to the MCU on request.
module vcxo_lock_monitor #(
  parameter int LOCK_WINDOW   = 10,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_WINDOW = 50,
  parameter int BIT_DIV       = 4
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic signed [31:0] freq_error,
  input  logic        [23:0] pwm,
  input  logic               rd_req,
  output logic               locked,
  output logic        [1:0]  lock_state,
  output logic        [7:0]  unlock_events,
  output logic               ser_busy,
  output logic               ser_data,
  output logic               ser_bit_stb,
  output logic               ser_done
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int DW = $clog2(BIT_DIV);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ACQUIRING = 2'd1,
    ST_LOCKED    = 2'd2
  } lock_st_t;

  lock_st_t       state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]     events_q, events_d;
  logic           sticky_q, sticky_d;
  logic           locked_q;
  logic           loss;
  logic [31:0]    abs_err;
  logic           in_window, over_unlock;
  logic [15:0]    fe_sat;
  logic [47:0]    frame;
  logic           snap;

  logic           busy_q, done_q;
  logic [47:0]    sh_q;
  logic [5:0]     bit_q;
  logic [DW-1:0]  div_q;

  // -2^31 has no positive counterpart at 32 bits, so it saturates.
  always_comb begin
    if (freq_error == 32'sh8000_0000)
      abs_err = 32'h7FFF_FFFF;
    else if (freq_error[31])
      abs_err = unsigned'(-freq_error);
    else
      abs_err = unsigned'(freq_error);
  end

  assign in_window   = abs_err <= 32'(LOCK_WINDOW);
  assign over_unlock = abs_err >  32'(UNLOCK_WINDOW);
  assign cnt_inc     = cnt_q + 1'b1;

  // rd_req is a bare strobe with no ready: it is taken only when the shifter is idle
  // (including the ser_done cycle); a request while ser_busy=1 is dropped, not queued.
  assign snap = rd_req && !busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    if (sample_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (in_window) begin
            cnt_d   = CW'(1);
            state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQUIRING;
          end
        end
        ST_ACQUIRING: begin
          if (in_window) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(LOCK_COUNT))
              state_d = ST_LOCKED;
          end else begin
            cnt_d   = '0;
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (over_unlock) begin
            cnt_d   = '0;
            state_d = ST_UNLOCKED;
            loss    = 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_UNLOCKED;
        end
      endcase
    end
    events_d = (loss && events_q != 8'hFF) ? events_q + 8'd1 : events_q;
    // A loss in the snapshot cycle must still be reported by the following frame.
    sticky_d = loss ? 1'b1 : (snap ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q  <= ST_UNLOCKED;
      cnt_q    <= '0;
      events_q <= '0;
      sticky_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      events_q <= events_d;
      sticky_q <= sticky_d;
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  always_comb begin
    if (freq_error > 32'sd32767)
      fe_sat = 16'h7FFF;
    else if (freq_error < -32'sd32768)
      fe_sat = 16'h8000;
    else
      fe_sat = freq_error[15:0];
  end

  assign frame = {state_q, sticky_q, events_q[4:0], fe_sat, pwm};

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sh_q   <= '0;
      bit_q  <= '0;
      div_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (snap) begin
        busy_q <= 1'b1;
        sh_q   <= frame;
        bit_q  <= 6'd47;
        div_q  <= '0;
      end else if (busy_q) begin
        if (div_q == DW'(BIT_DIV - 1)) begin
          div_q <= '0;
          if (bit_q == 6'd0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            bit_q <= bit_q - 6'd1;
            sh_q  <= {sh_q[46:0], 1'b0};
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  assign locked        = locked_q;
  assign lock_state    = state_q;
  assign unlock_events = events_q;
  assign ser_busy      = busy_q;
  assign ser_data      = busy_q & sh_q[47];
  assign ser_bit_stb   = busy_q && (div_q == '0);
  assign ser_done      = done_q;

endmodule
